// File: rtl/magic_serial_adder_if.sv
// Operand/result handshake bundle for magic_serial_adder.
// The producer side (master) drives operands and out_ready; the adder (slave)
// drives in_ready, the result and the micro-op counter.
// Optional build macro: MAGIC_SUB_EN adds the 1-bit 'sub' request line.
interface magic_serial_adder_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef MAGIC_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [OPW-1:0]   op_count;

`ifdef MAGIC_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, op_count
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, op_count
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, op_count
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, op_count
  );
`endif
endinterface

// File: rtl/magic_serial_adder.sv
// magic_serial_adder: bit-serial ripple adder evaluated one NOR/NOT micro-op
// per clock, mimicking a MAGIC memristor crossbar row. Each bit runs the
// nine-NOR full-adder network n1..n9 (LSB first); n8 is the sum bit and n9
// the carry into the next bit.
// Optional build macro: MAGIC_SUB_EN adds a subtract request. A leading
// micro-op per bit forms bx = sub ? NOR(b,b) : b, and the carry starts at 1,
// giving a - b with cout=1 meaning "no borrow".
module magic_serial_adder #(
  parameter int WIDTH = 8,
  parameter int OPW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  magic_serial_adder_if.slave  bus
);

`ifdef MAGIC_SUB_EN
  // Ten steps per bit: bx, then n1..n9. Scratch slot 0 holds bx.
  localparam int SCR_LO = 0;
  localparam int STEPS  = 10;
`else
  // Nine steps per bit: n1..n9. No bx slot is needed.
  localparam int SCR_LO = 1;
  localparam int STEPS  = 9;
`endif
  localparam logic [3:0] LAST_K = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // One crossbar NOR gate; NOT is NOR with both inputs tied together.
  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] mask_q;      // one-hot pointer to the bit under evaluation
  logic [WIDTH-1:0] sum_q;       // sum bits gathered during the current run
  logic [WIDTH-1:0] s_q;         // published result, kept until next completion
  logic             carry_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [3:0]       k_q;         // micro-op step within the current bit
  logic [OPW-1:0]   op_count_q;
  logic [8:SCR_LO]  scr_q;       // scratch cells n1..n8 (plus bx when enabled)
`ifdef MAGIC_SUB_EN
  logic             sub_q;
`endif

  logic             a_bit_s;
  logic             b_bit_s;
  logic             bx_s;
  logic             n1_s, n2_s, n3_s, n4_s, n5_s, n6_s, n7_s, n8_s;
  logic [3:0]       op_idx_s;    // 0..8 selects n1..n9
  logic [3:0]       wr_idx_s;    // scratch slot written by this step
  logic             uop_s;       // value produced by this cycle's micro-op
  logic [WIDTH-1:0] sum_d;
  logic [OPW-1:0]   op_count_d;

  // Select the operand bits and scratch cells feeding the current micro-op.
  always_comb begin
    a_bit_s = |(a_q & mask_q);
    b_bit_s = |(b_q & mask_q);
`ifdef MAGIC_SUB_EN
    bx_s     = scr_q[0];
    op_idx_s = k_q - 4'd1;
`else
    bx_s     = b_bit_s;
    op_idx_s = k_q;
`endif
    wr_idx_s = k_q + 4'(SCR_LO);
    n1_s = scr_q[1];
    n2_s = scr_q[2];
    n3_s = scr_q[3];
    n4_s = scr_q[4];
    n5_s = scr_q[5];
    n6_s = scr_q[6];
    n7_s = scr_q[7];
    n8_s = scr_q[8];
  end

  // Evaluate exactly one NOR gate of the full-adder network for step k.
  always_comb begin
    uop_s = 1'b0;
    case (op_idx_s)
      4'd0:    uop_s = nor2(a_bit_s, bx_s);   // n1
      4'd1:    uop_s = nor2(a_bit_s, n1_s);   // n2 = ~a & b
      4'd2:    uop_s = nor2(bx_s, n1_s);      // n3 = a & ~b
      4'd3:    uop_s = nor2(n2_s, n3_s);      // n4 = XNOR(a,b)
      4'd4:    uop_s = nor2(n4_s, carry_q);   // n5
      4'd5:    uop_s = nor2(n4_s, n5_s);      // n6
      4'd6:    uop_s = nor2(carry_q, n5_s);   // n7
      4'd7:    uop_s = nor2(n6_s, n7_s);      // n8 = sum
      4'd8:    uop_s = nor2(n1_s, n5_s);      // n9 = carry out
      default: uop_s = 1'b0;
    endcase
`ifdef MAGIC_SUB_EN
    if (k_q == 4'd0) begin
      uop_s = sub_q ? nor2(b_bit_s, b_bit_s) : b_bit_s;   // bx
    end else begin
      uop_s = uop_s;
    end
`endif
  end

  // Next values for the gathered sum and the saturating micro-op counter.
  always_comb begin
    sum_d = sum_q | (mask_q & {WIDTH{n8_s}});
    if (&op_count_q) begin
      op_count_d = op_count_q;
    end else begin
      op_count_d = op_count_q + OPW'(1);
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      mask_q      <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      s_q         <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      k_q         <= 4'd0;
      op_count_q  <= {OPW{1'b0}};
      scr_q       <= '0;
`ifdef MAGIC_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
`ifdef MAGIC_SUB_EN
            sub_q      <= bus.sub;
            carry_q    <= bus.sub ? 1'b1 : bus.cin;
`else
            carry_q    <= bus.cin;
`endif
            mask_q     <= WIDTH'(1'b1);
            sum_q      <= {WIDTH{1'b0}};
            k_q        <= 4'd0;
            op_count_q <= {OPW{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= EVAL;
          end
        end
        EVAL: begin
          op_count_q <= op_count_d;
          if (k_q == LAST_K) begin
            // n9 is consumed directly as the next carry; n8 is already in scratch.
            k_q     <= 4'd0;
            carry_q <= uop_s;
            sum_q   <= sum_d;
            mask_q  <= mask_q << 1;
            if (mask_q[WIDTH-1]) begin
              s_q         <= sum_d;
              cout_q      <= uop_s;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            scr_q[wr_idx_s] <= uop_s;
            k_q             <= k_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_magic_serial_adder.sv
// Directed bench for magic_serial_adder: an 8-bit and a 1-bit instance,
// scoreboard of expected results pushed at accept and popped at out_valid.
// Optional build macro: MAGIC_SUB_EN enables the subtract cases.
module tb_magic_serial_adder;
  localparam int W   = 8;
  localparam int OPW = 16;
`ifdef MAGIC_SUB_EN
  localparam int S = 10;
`else
  localparam int S = 9;
`endif

  typedef struct packed {
    logic [W-1:0]   s;
    logic           c;
    logic [OPW-1:0] n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   t_acc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  exp_t got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  magic_serial_adder_if #(.WIDTH(W), .OPW(OPW)) bus8 ();
  magic_serial_adder_if #(.WIDTH(1), .OPW(OPW)) bus1 ();

  magic_serial_adder #(.WIDTH(W), .OPW(OPW)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  magic_serial_adder #(.WIDTH(1), .OPW(OPW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for in_ready, present one operand set, push the expected result.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    int   n;
    logic [8:0] r;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus8.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", 32'(bus8.in_ready), 32'd1);
    bus8.a   = a;
    bus8.b   = b;
    bus8.cin = c;
`ifdef MAGIC_SUB_EN
    bus8.sub = sub;
`endif
    bus8.in_valid = 1'b1;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else     r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    e.s = r[7:0];
    e.c = r[8];
    e.n = 16'(W * S);
    sb.push_back(e);
    t_acc = cyc;
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency and the popped expectation.
  task automatic recv8(output exp_t e);
    int n;
    n = 0;
    e = '0;
    while (!bus8.out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(cyc - t_acc), 32'(W * S + 1));
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sum", 32'(bus8.s), 32'(e.s));
      check("cout", 32'(bus8.cout), 32'(e.c));
      check("op_count", 32'(bus8.op_count), 32'(e.n));
    end
  endtask

  task automatic consume8();
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("in_ready_after_consume", 32'(bus8.in_ready), 32'd1);
    check("out_valid_after_consume", 32'(bus8.out_valid), 32'd0);
  endtask

  // Full transaction on the 1-bit instance.
  task automatic run1(input logic a, input logic b, input logic c);
    int   n;
    int   t1;
    logic [1:0] r;
    n = 0;
    @(negedge clk);
    while (!bus1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    r = {1'b0, a} + {1'b0, b} + {1'b0, c};
    bus1.a = a;
    bus1.b = b;
    bus1.cin = c;
    bus1.in_valid = 1'b1;
    t1 = cyc;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w1_latency", 32'(cyc - t1), 32'(S + 1));
    check("w1_sum_cout", 32'({bus1.cout, bus1.s}), 32'(r));
    check("w1_op_count", 32'(bus1.op_count), 32'(S));
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
`ifdef MAGIC_SUB_EN
    bus8.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_s", 32'(bus8.s), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    check("rst_op_count", 32'(bus8.op_count), 32'd0);
    rst = 1'b0;

    // Basic sum and the carry-out corner cases.
    send8(8'h5A, 8'h3C, 1'b0, 1'b0); recv8(got); consume8();
    send8(8'hFF, 8'h01, 1'b0, 1'b0); recv8(got); consume8();
    send8(8'hFF, 8'hFF, 1'b1, 1'b0); recv8(got); consume8();
    send8(8'h00, 8'h00, 1'b0, 1'b0); recv8(got); consume8();

    // Back-pressure: result and counter hold, new requests are ignored.
    send8(8'h12, 8'h34, 1'b1, 1'b0);
    recv8(got);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus8.in_valid = (i % 2 == 0);
      bus8.a = 8'hAA;
      bus8.b = 8'h55;
      check("hold_out_valid", 32'(bus8.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus8.in_ready), 32'd0);
      check("hold_s", 32'(bus8.s), 32'(got.s));
      check("hold_cout", 32'(bus8.cout), 32'(got.c));
      check("hold_op_count", 32'(bus8.op_count), 32'(got.n));
    end
    bus8.in_valid = 1'b0;
    consume8();
    repeat (3) @(negedge clk);
    check("idle_keeps_s", 32'(bus8.s), 32'(got.s));
    check("idle_keeps_cout", 32'(bus8.cout), 32'(got.c));

    // Reset during EVAL cycle 30 discards the run.
    send8(8'h77, 8'h11, 1'b0, 1'b0);
    while (cyc < t_acc + 30) @(negedge clk);
    check("mid_eval_op_count", 32'(bus8.op_count), 32'd29);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("mid_rst_s", 32'(bus8.s), 32'd0);
    check("mid_rst_op_count", 32'(bus8.op_count), 32'd0);
    rst = 1'b0;
    sb.delete();
    send8(8'h77, 8'h11, 1'b0, 1'b0); recv8(got); consume8();

    // A handful of random sums.
    for (int i = 0; i < 5; i++) begin
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      recv8(got);
      consume8();
    end

    // Exhaustive single-bit full adder.
    for (int i = 0; i < 8; i++) begin
      run1(i[2], i[1], i[0]);
    end

`ifdef MAGIC_SUB_EN
    send8(8'h10, 8'h01, 1'b0, 1'b1); recv8(got); consume8();
    send8(8'h01, 8'h02, 1'b0, 1'b1); recv8(got); consume8();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
